// File: rtl/irq_ctrl.sv
// irq_ctrl: four-source priority interrupt controller on the aux bus.
// Registers at BASE+0..3: MASK, PEND (W1C), VECTOR (read acknowledges), EOI.
// A single request/service/ack handshake is in flight at a time; the ack
// pulse is steered back to the source that was serviced.
module irq_ctrl #(
  parameter logic [15:0] BASE = 16'h0110
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] auxdaddr,
  input  logic [7:0]  auxdin,
  input  logic        auxwe,
  input  logic        auxre,
  input  logic [3:0]  src,
  output logic [7:0]  auxdout,
  output logic        auxdoutsel,
  output logic        cpu_irq,
  output logic [3:0]  ack
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ASSERT  = 2'd1,
    S_SERVICE = 2'd2,
    S_ACK     = 2'd3
  } state_t;

  state_t      state_reg;
  logic [3:0]  mask_reg;
  logic [3:0]  pend_reg;
  logic [3:0]  src_d_reg;
  logic [1:0]  insvc_reg;
  logic        cpu_irq_reg;
  logic [3:0]  ack_reg;

  logic        hit_mask, hit_pend, hit_vec, hit_eoi;
  logic [3:0]  rise;
  logic [3:0]  pend_masked;
  logic        any_pend;
  logic [1:0]  id;
  logic        vec_read;
  logic        eoi_write;
  logic [3:0]  w1c_bits;
  logic [3:0]  svc_clear;
  logic [3:0]  mask_next;
  logic [3:0]  pend_next;
  logic [7:0]  vector_val;

  // Upper data bits have no meaning in any register.
  logic        unused_din_bits;
  assign unused_din_bits = ^auxdin[7:4];

  assign hit_mask   = (auxdaddr == BASE);
  assign hit_pend   = (auxdaddr == BASE + 16'd1);
  assign hit_vec    = (auxdaddr == BASE + 16'd2);
  assign hit_eoi    = (auxdaddr == BASE + 16'd3);
  assign auxdoutsel = (auxdaddr >= BASE) && (auxdaddr <= BASE + 16'd3);

  assign rise        = src & ~src_d_reg;
  assign pend_masked = pend_reg & mask_reg;
  assign any_pend    = |pend_masked;

  // Lowest-index enabled pending source wins.
  always_comb begin
    id = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (pend_masked[i]) id = 2'(i);
    end
  end

  // Reading VECTOR only acknowledges while a request is actually presented.
  assign vec_read  = auxre && hit_vec && (state_reg == S_ASSERT) && any_pend;
  assign eoi_write = auxwe && hit_eoi;
  assign w1c_bits  = (auxwe && hit_pend) ? auxdin[3:0] : 4'h0;
  assign svc_clear = vec_read ? (4'b0001 << id) : 4'h0;
  assign mask_next = (auxwe && hit_mask) ? auxdin[3:0] : mask_reg;

  // A new rising edge always beats a same-edge clear, so no event is lost.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_pend
      assign pend_next[gi] = rise[gi] | (pend_reg[gi] & ~w1c_bits[gi] & ~svc_clear[gi]);
    end
  endgenerate

  assign vector_val = (state_reg == S_ASSERT && any_pend) ? {6'b100000, id} : 8'h00;

  // Register read mux; EOI and unused bits read as zero.
  always_comb begin
    auxdout = 8'h00;
    if (hit_mask)      auxdout = {4'h0, mask_reg};
    else if (hit_pend) auxdout = {4'h0, pend_reg};
    else if (hit_vec)  auxdout = vector_val;
  end

  // Source sampling, mask and pending register updates.
  always_ff @(posedge clk) begin
    if (!rst) begin
      mask_reg  <= 4'h0;
      pend_reg  <= 4'h0;
      src_d_reg <= 4'h0;
    end else begin
      mask_reg  <= mask_next;
      pend_reg  <= pend_next;
      src_d_reg <= src;
    end
  end

  // Request/service/ack sequencer with registered cpu_irq and ack outputs.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg   <= S_IDLE;
      insvc_reg   <= 2'd0;
      cpu_irq_reg <= 1'b0;
      ack_reg     <= 4'h0;
    end else begin
      ack_reg <= 4'h0;
      case (state_reg)
        S_IDLE: begin
          if (any_pend) begin
            state_reg   <= S_ASSERT;
            cpu_irq_reg <= 1'b1;
          end
        end
        S_ASSERT: begin
          if (vec_read) begin
            state_reg   <= S_SERVICE;
            insvc_reg   <= id;
            cpu_irq_reg <= 1'b0;
          end else if ((pend_next & mask_next) == 4'h0) begin
            state_reg   <= S_IDLE;
            cpu_irq_reg <= 1'b0;
          end
        end
        S_SERVICE: begin
          if (eoi_write) begin
            state_reg <= S_ACK;
            ack_reg   <= 4'b0001 << insvc_reg;
          end
        end
        S_ACK: begin
          state_reg <= S_IDLE;
        end
        default: begin
          state_reg   <= S_IDLE;
          cpu_irq_reg <= 1'b0;
        end
      endcase
    end
  end

  assign cpu_irq = cpu_irq_reg;
  assign ack     = ack_reg;

endmodule

// File: tb/tb_irq_ctrl.sv
// tb_irq_ctrl: directed scenarios plus randomized traffic checked against a
// cycle-level behavioural model of the interrupt controller.
`timescale 1ns/100ps
module tb_irq_ctrl;

  localparam logic [15:0] B = 16'h0110;
  localparam int P_IDLE = 0, P_ASSERT = 1, P_SERVICE = 2, P_ACK = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] auxdaddr;
  logic [7:0]  auxdin;
  logic        auxwe, auxre;
  logic [3:0]  src;
  logic [7:0]  auxdout;
  logic        auxdoutsel, cpu_irq;
  logic [3:0]  ack;

  int checks = 0;
  int errors = 0;

  // model state
  logic [3:0] m_mask, m_pend, m_srcd, m_ack;
  int         m_ph, m_insvc;
  bit         m_irq;

  irq_ctrl #(.BASE(B)) dut (
    .clk(clk), .rst(rst), .auxdaddr(auxdaddr), .auxdin(auxdin),
    .auxwe(auxwe), .auxre(auxre), .src(src), .auxdout(auxdout),
    .auxdoutsel(auxdoutsel), .cpu_irq(cpu_irq), .ack(ack)
  );

  always #10 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  function automatic int low_id(input logic [3:0] v);
    int r = 0;
    for (int i = 3; i >= 0; i--) if (v[i]) r = i;
    return r;
  endfunction

  function automatic logic [7:0] m_dout(input logic [15:0] a);
    logic [3:0] pm = m_pend & m_mask;
    if (a == B) return {4'h0, m_mask};
    if (a == B + 16'd1) return {4'h0, m_pend};
    if (a == B + 16'd2) return (m_ph == P_ASSERT && pm != 0) ? (8'h80 | 8'(low_id(pm))) : 8'h00;
    return 8'h00;
  endfunction

  // Advance one clock: predict from current inputs, then commit after the edge.
  task automatic tick();
    logic [3:0] rise, pm, pend_n, mask_n, ack_n, srcd_n;
    int id, ph_n, insvc_n;
    bit irq_n, vread;
    if (!rst) begin
      mask_n = 0; pend_n = 0; srcd_n = 0; ph_n = P_IDLE; insvc_n = 0; ack_n = 0; irq_n = 0;
    end else begin
      rise   = src & ~m_srcd;
      pm     = m_pend & m_mask;
      id     = low_id(pm);
      srcd_n = src;
      mask_n = (auxwe && auxdaddr == B) ? auxdin[3:0] : m_mask;
      pend_n = m_pend;
      if (auxwe && auxdaddr == B + 16'd1) pend_n = pend_n & ~auxdin[3:0];
      vread  = auxre && (auxdaddr == B + 16'd2) && (m_ph == P_ASSERT) && (pm != 0);
      if (vread) pend_n[id] = 1'b0;
      pend_n  = pend_n | rise;
      ph_n    = m_ph;
      insvc_n = m_insvc;
      ack_n   = 0;
      case (m_ph)
        P_IDLE:    if (pm != 0) ph_n = P_ASSERT;
        P_ASSERT:  if (vread) begin ph_n = P_SERVICE; insvc_n = id; end
                   else if ((pend_n & mask_n) == 0) ph_n = P_IDLE;
        P_SERVICE: if (auxwe && auxdaddr == B + 16'd3) begin ph_n = P_ACK; ack_n = 4'(1 << m_insvc); end
        default:   ph_n = P_IDLE;
      endcase
      irq_n = (ph_n == P_ASSERT);
    end
    @(posedge clk);
    #1;
    m_mask = mask_n; m_pend = pend_n; m_srcd = srcd_n; m_ph = ph_n;
    m_insvc = insvc_n; m_ack = ack_n; m_irq = irq_n;
  endtask

  task automatic wr(input logic [15:0] a, input logic [7:0] d);
    auxdaddr = a; auxdin = d; auxwe = 1'b1;
    tick();
    auxwe = 1'b0;
  endtask

  task automatic peek(input logic [15:0] a);
    auxdaddr = a; #1;
  endtask

  task automatic test_reset();
    rst = 1'b0; tick(); rst = 1'b1;
    checks++; if (cpu_irq !== 1'b0) begin errors++; $display("FAIL reset_irq: got %b expected 0", cpu_irq); end
    checks++; if (ack !== 4'h0) begin errors++; $display("FAIL reset_ack: got %h expected 0", ack); end
    peek(B);
    checks++; if (auxdout !== 8'h00) begin errors++; $display("FAIL reset_mask: got %h expected 00", auxdout); end
    checks++; if (auxdoutsel !== 1'b1) begin errors++; $display("FAIL sel_0110: got %b expected 1", auxdoutsel); end
    peek(B + 16'd1);
    checks++; if (auxdout !== 8'h00) begin errors++; $display("FAIL reset_pend: got %h expected 00", auxdout); end
    peek(B + 16'd2);
    checks++; if (auxdout !== 8'h00) begin errors++; $display("FAIL reset_vec: got %h expected 00", auxdout); end
    peek(16'h0114);
    checks++; if (auxdoutsel !== 1'b0) begin errors++; $display("FAIL sel_0114: got %b expected 0", auxdoutsel); end
    $display("test_reset done");
  endtask

  task automatic test_dma_flow();
    wr(B, 8'h01);
    src = 4'b0001; tick();
    peek(B + 16'd1);
    checks++; if (auxdout !== 8'h01) begin errors++; $display("FAIL dma_pend: got %h expected 01", auxdout); end
    checks++; if (cpu_irq !== 1'b0) begin errors++; $display("FAIL dma_irq_early: got %b expected 0", cpu_irq); end
    tick();
    checks++; if (cpu_irq !== 1'b1) begin errors++; $display("FAIL dma_irq: got %b expected 1", cpu_irq); end
    auxdaddr = B + 16'd2; auxre = 1'b1; #1;
    checks++; if (auxdout !== 8'h80) begin errors++; $display("FAIL dma_vec: got %h expected 80", auxdout); end
    tick(); auxre = 1'b0;
    checks++; if (cpu_irq !== 1'b0) begin errors++; $display("FAIL dma_irq_drop: got %b expected 0", cpu_irq); end
    peek(B + 16'd1);
    checks++; if (auxdout !== 8'h00) begin errors++; $display("FAIL dma_pend_clr: got %h expected 00", auxdout); end
    src = 4'b0000;
    wr(B + 16'd3, 8'hA5);
    checks++; if (ack !== 4'b0001) begin errors++; $display("FAIL dma_ack: got %b expected 0001", ack); end
    tick();
    checks++; if (ack !== 4'b0000) begin errors++; $display("FAIL dma_ack_end: got %b expected 0000", ack); end
    $display("test_dma_flow done");
  endtask

  task automatic test_priority();
    src = 4'b0000; tick();
    wr(B, 8'h0F);
    src = 4'b0110; tick(); tick();
    checks++; if (cpu_irq !== 1'b1) begin errors++; $display("FAIL prio_irq1: got %b expected 1", cpu_irq); end
    auxdaddr = B + 16'd2; auxre = 1'b1; #1;
    checks++; if (auxdout !== 8'h81) begin errors++; $display("FAIL prio_vec1: got %h expected 81", auxdout); end
    tick(); auxre = 1'b0;
    wr(B + 16'd3, 8'h00);
    checks++; if (ack !== 4'b0010) begin errors++; $display("FAIL prio_ack1: got %b expected 0010", ack); end
    tick(); tick();
    checks++; if (cpu_irq !== 1'b1) begin errors++; $display("FAIL prio_irq2: got %b expected 1", cpu_irq); end
    auxdaddr = B + 16'd2; auxre = 1'b1; #1;
    checks++; if (auxdout !== 8'h82) begin errors++; $display("FAIL prio_vec2: got %h expected 82", auxdout); end
    tick(); auxre = 1'b0;
    wr(B + 16'd3, 8'h00);
    checks++; if (ack !== 4'b0100) begin errors++; $display("FAIL prio_ack2: got %b expected 0100", ack); end
    tick();
    src = 4'b0000; tick();
    $display("test_priority done");
  endtask

  task automatic test_masking();
    bit seen;
    wr(B, 8'h0E);
    src = 4'b0001; tick();
    peek(B + 16'd1);
    checks++; if (auxdout !== 8'h01) begin errors++; $display("FAIL mask_pend: got %h expected 01", auxdout); end
    tick(); tick();
    checks++; if (cpu_irq !== 1'b0) begin errors++; $display("FAIL mask_irq_off: got %b expected 0", cpu_irq); end
    wr(B, 8'h0F);
    seen = cpu_irq;
    for (int i = 0; i < 2 && !seen; i++) begin tick(); seen = cpu_irq; end
    checks++; if (seen !== 1'b1) begin errors++; $display("FAIL mask_unmask_irq: got 0 expected 1 within 2 cycles"); end
    wr(B, 8'h00); tick();
    checks++; if (cpu_irq !== 1'b0) begin errors++; $display("FAIL mask_remask_irq: got %b expected 0", cpu_irq); end
    peek(B + 16'd1);
    checks++; if (auxdout !== 8'h01) begin errors++; $display("FAIL mask_pend_kept: got %h expected 01", auxdout); end
    wr(B + 16'd1, 8'h0F);
    src = 4'b0000; tick();
    $display("test_masking done");
  endtask

  task automatic test_collision();
    auxdaddr = B + 16'd1; auxdin = 8'h01; auxwe = 1'b1; src = 4'b0001;
    tick(); auxwe = 1'b0;
    peek(B + 16'd1);
    checks++; if (auxdout !== 8'h01) begin errors++; $display("FAIL collision_pend: got %h expected 01", auxdout); end
    wr(B + 16'd1, 8'h01);
    peek(B + 16'd1);
    checks++; if (auxdout !== 8'h00) begin errors++; $display("FAIL w1c_pend: got %h expected 00", auxdout); end
    src = 4'b0000; tick();
    $display("test_collision done");
  endtask

  task automatic test_abort();
    wr(B, 8'h01);
    src = 4'b0001; tick(); tick();
    auxdaddr = B + 16'd2; auxre = 1'b1; tick(); auxre = 1'b0;
    src = 4'b0000; rst = 1'b0; tick(); rst = 1'b1;
    peek(B);
    checks++; if (auxdout !== 8'h00) begin errors++; $display("FAIL abort_mask: got %h expected 00", auxdout); end
    peek(B + 16'd1);
    checks++; if (auxdout !== 8'h00) begin errors++; $display("FAIL abort_pend: got %h expected 00", auxdout); end
    peek(B + 16'd2);
    checks++; if (auxdout !== 8'h00) begin errors++; $display("FAIL abort_vec: got %h expected 00", auxdout); end
    wr(B + 16'd3, 8'h00);
    for (int i = 0; i < 4; i++) begin
      checks++; if (ack !== 4'h0 || cpu_irq !== 1'b0) begin errors++; $display("FAIL abort_quiet: got ack=%b irq=%b expected ack=0000 irq=0", ack, cpu_irq); end
      tick();
    end
    $display("test_abort done");
  endtask

  task automatic test_random();
    for (int n = 0; n < 600; n++) begin
      auxdaddr = B - 16'd1 + 16'($urandom_range(0, 5));
      auxdin   = 8'($urandom);
      auxwe    = ($urandom_range(0, 3) == 0);
      auxre    = ($urandom_range(0, 2) == 0);
      for (int b = 0; b < 4; b++) if ($urandom_range(0, 7) == 0) src[b] = ~src[b];
      rst      = ($urandom_range(0, 99) != 0);
      tick();
      checks++; if (cpu_irq !== m_irq) begin errors++; $display("FAIL rand_irq[%0d]: got %b expected %b", n, cpu_irq, m_irq); end
      checks++; if (ack !== m_ack) begin errors++; $display("FAIL rand_ack[%0d]: got %b expected %b", n, ack, m_ack); end
      checks++; if (auxdout !== m_dout(auxdaddr)) begin errors++; $display("FAIL rand_dout[%0d]: addr %h got %h expected %h", n, auxdaddr, auxdout, m_dout(auxdaddr)); end
      checks++; if (auxdoutsel !== (auxdaddr >= B && auxdaddr <= B + 16'd3)) begin errors++; $display("FAIL rand_sel[%0d]: addr %h got %b", n, auxdaddr, auxdoutsel); end
    end
    rst = 1'b1; auxwe = 1'b0; auxre = 1'b0;
    $display("test_random done");
  endtask

  initial begin
    rst = 1'b0; auxdaddr = 16'h0; auxdin = 8'h0; auxwe = 1'b0; auxre = 1'b0; src = 4'h0;
    m_mask = 0; m_pend = 0; m_srcd = 0; m_ack = 0; m_ph = P_IDLE; m_insvc = 0; m_irq = 0;
    test_reset();
    test_dma_flow();
    test_priority();
    test_masking();
    test_collision();
    test_abort();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
